// File: rtl/drum_pkg.sv
// drum_pkg: shared widths, saturation limits and pacer state encoding
// for the drum-mesh audio path.
package drum_pkg;
    localparam int Q_W   = 18;
    localparam int AUD_W = 32;
    localparam logic [AUD_W-1:0] SAT_MAX = 32'h7FFF_FFFF;
    localparam logic [AUD_W-1:0] SAT_MIN = 32'h8000_0000;
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_KICK    = 3'd1,
        S_DROP    = 3'd2,
        S_WAIT    = 3'd3,
        S_CAPTURE = 3'd4,
        S_SEND_L  = 3'd5,
        S_SEND_R  = 3'd6
    } pacer_state_t;
endpackage

// File: rtl/drum_sample_format.sv
// drum_sample_format: signed Q1.17 sample to 32-bit audio word, left-shifted
// by 14+GAIN_SHIFT with saturation when the shifted value no longer fits.
module drum_sample_format
    import drum_pkg::*;
#(
    parameter int GAIN_SHIFT = 0
) (
    input  logic [Q_W-1:0]   i_x,
    output logic [AUD_W-1:0] o_y
);
    localparam int SH = 14 + GAIN_SHIFT;
    localparam int WW = Q_W + SH;
    logic [WW-1:0] w_wide;
    logic          w_ovf;
    // Overflow when any bit above the result's sign bit disagrees with the sign.
    always_comb begin
        w_wide = {i_x, {SH{1'b0}}};
        w_ovf  = w_wide[WW-1:AUD_W-1] != {(WW-AUD_W+1){i_x[Q_W-1]}};
        o_y    = w_ovf ? (i_x[Q_W-1] ? SAT_MIN : SAT_MAX) : w_wide[AUD_W-1:0];
    end
endmodule

// File: rtl/drum_audio_pacer.sv
// drum_audio_pacer: kicks mesh iterations, waits for all columns, then streams
// the center sample as a left/right audio pair under sink back-pressure.
module drum_audio_pacer
    import drum_pkg::*;
#(
    parameter int N_COLS     = 32,
    parameter int GAIN_SHIFT = 0,
    parameter int TIMEOUT    = 4095
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    input  logic [N_COLS-1:0] columns_done,
    input  logic [Q_W-1:0]    center_node,
    output logic              iteration_enable,
    output logic [AUD_W-1:0]  aud_data,
    output logic              aud_chan,
    output logic              aud_valid,
    input  logic              aud_ready,
    output logic [15:0]       iter_cycles,
    output logic [15:0]       sample_count,
    output logic              timeout_err,
    output logic              busy
);
    localparam logic [15:0] TO = 16'(TIMEOUT);
    pacer_state_t   r_state;
    logic [Q_W-1:0] r_sample;
    logic [15:0]    r_cnt, r_iter, r_count;
    logic           r_en, r_chan, r_valid, r_timeout, r_busy;
    logic           w_all_done;
    logic [AUD_W-1:0] w_word;

    assign w_all_done = &columns_done;

    drum_sample_format #(.GAIN_SHIFT(GAIN_SHIFT)) u_fmt (
        .i_x (r_sample),
        .o_y (w_word)
    );

    // Outputs are registered alongside the state they belong to.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_sample  <= '0;
            r_cnt     <= '0;
            r_iter    <= '0;
            r_count   <= '0;
            r_en      <= 1'b0;
            r_chan    <= 1'b0;
            r_valid   <= 1'b0;
            r_timeout <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_en <= 1'b0;
            case (r_state)
                S_IDLE: if (run && w_all_done && !r_timeout) begin
                    r_state <= S_KICK;
                    r_en    <= 1'b1;
                    r_busy  <= 1'b1;
                end
                S_KICK: begin
                    r_cnt   <= '0;
                    r_state <= S_DROP;
                end
                S_DROP: begin
                    r_cnt   <= r_cnt + 16'd1;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    r_cnt <= (r_cnt == 16'hFFFF) ? r_cnt : r_cnt + 16'd1;
                    if (w_all_done) begin
                        r_iter  <= r_cnt;
                        r_state <= S_CAPTURE;
                    end else if (r_cnt == TO) begin
                        r_timeout <= 1'b1;
                        r_busy    <= 1'b0;
                        r_state   <= S_IDLE;
                    end
                end
                S_CAPTURE: begin
                    r_sample <= center_node;
                    r_valid  <= 1'b1;
                    r_chan   <= 1'b0;
                    r_state  <= S_SEND_L;
                end
                S_SEND_L: if (aud_ready) begin
                    r_chan  <= 1'b1;
                    r_state <= S_SEND_R;
                end
                S_SEND_R: if (aud_ready) begin
                    r_valid <= 1'b0;
                    r_count <= r_count + 16'd1;
                    r_en    <= run;
                    r_busy  <= run;
                    r_state <= run ? S_KICK : S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign iteration_enable = r_en;
    assign aud_data         = w_word;
    assign aud_chan         = r_chan;
    assign aud_valid        = r_valid;
    assign iter_cycles      = r_iter;
    assign sample_count     = r_count;
    assign timeout_err      = r_timeout;
    assign busy             = r_busy;
endmodule

// File: tb/tb_drum_audio_pacer.sv
// tb_drum_audio_pacer: directed checks of pacing, conversion, back-pressure,
// timeout and reset; d1 uses GAIN_SHIFT=2 and TIMEOUT=50.
module tb_drum_audio_pacer;
    logic        clk = 1'b0;
    logic        reset, run, aud_ready;
    logic [31:0] columns_done;
    logic [17:0] center_node;
    logic        en0, chan0, valid0, to0, busy0;
    logic        en1, chan1, valid1, to1, busy1;
    logic [31:0] data0, data1;
    logic [15:0] iter0, cnt0, iter1, cnt1;
    int          errors = 0;
    int          checks = 0;
    logic        bad;

    always #5 clk = ~clk;

    drum_audio_pacer d0 (
        .clk(clk), .reset(reset), .run(run), .columns_done(columns_done),
        .center_node(center_node), .iteration_enable(en0), .aud_data(data0),
        .aud_chan(chan0), .aud_valid(valid0), .aud_ready(aud_ready),
        .iter_cycles(iter0), .sample_count(cnt0), .timeout_err(to0), .busy(busy0)
    );

    drum_audio_pacer #(.GAIN_SHIFT(2), .TIMEOUT(50)) d1 (
        .clk(clk), .reset(reset), .run(run), .columns_done(columns_done),
        .center_node(center_node), .iteration_enable(en1), .aud_data(data1),
        .aud_chan(chan1), .aud_valid(valid1), .aud_ready(aud_ready),
        .iter_cycles(iter1), .sample_count(cnt1), .timeout_err(to1), .busy(busy1)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        reset = 1'b1; run = 1'b0; aud_ready = 1'b0;
        columns_done = '1; center_node = '0;
        tick(3);
        chk("rst_en",    32'(en0),    0);
        chk("rst_valid", 32'(valid0), 0);
        chk("rst_busy",  32'(busy0),  0);
        chk("rst_data",  data0,       0);
        chk("rst_cnt",   32'(cnt0),   0);
        chk("rst_iter",  32'(iter0),  0);
        chk("rst_to",    32'(to0),    0);
        // kick, 1-cycle pulse, done drops then rises 100 cycles later
        reset = 1'b0; run = 1'b1; aud_ready = 1'b1; center_node = 18'h10000;
        tick(1);
        chk("kick_en",   32'(en0),   1);
        chk("kick_busy", 32'(busy0), 1);
        tick(1);
        chk("pulse_w1",  32'(en0),   0);
        chk("drop_busy", 32'(busy0), 1);
        columns_done = '0;
        tick(1);
        chk("stale_done", 32'(valid0), 0);
        tick(99);
        columns_done = '1;
        tick(1);
        chk("iter_100", 32'(iter0), 100);
        tick(1);
        chk("l_valid", 32'(valid0), 1);
        chk("l_chan",  32'(chan0),  0);
        chk("l_data",  data0,       32'h4000_0000);
        tick(1);
        chk("r_valid", 32'(valid0), 1);
        chk("r_chan",  32'(chan0),  1);
        chk("r_data",  data0,       32'h4000_0000);
        tick(1);
        chk("cnt_1",      32'(cnt0),  1);
        chk("rekick",     32'(en0),   1);
        chk("d1_to_set",  32'(to1),   1);
        chk("d1_to_idle", 32'(busy1), 0);
        chk("d1_no_kick", 32'(en1),   0);
        // back-pressure during SEND_L
        aud_ready = 1'b0; columns_done = '0; center_node = 18'h2ABCD;
        tick(4);
        columns_done = '1;
        tick(2);
        chk("bp_valid", 32'(valid0), 1);
        chk("bp_data",  data0,       32'hAAF3_4000);
        bad = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            bad |= (data0 !== 32'hAAF3_4000) | (chan0 !== 1'b0) | (valid0 !== 1'b1) | (en0 !== 1'b0);
        end
        chk("bp_stable", 32'(bad), 0);
        aud_ready = 1'b1;
        tick(1);
        chk("bp_r_chan",  32'(chan0), 1);
        chk("bp_r_valid", 32'(valid0), 1);
        chk("bp_r_noen",  32'(en0),   0);
        tick(1);
        chk("bp_kick", 32'(en0),  1);
        chk("cnt_2",   32'(cnt0), 2);
        // run dropped during WAIT_DONE: pair completes, then IDLE
        columns_done = '0;
        tick(2);
        run = 1'b0; center_node = 18'h00001;
        tick(2);
        columns_done = '1;
        tick(2);
        chk("stop_l_valid", 32'(valid0), 1);
        chk("stop_l_data",  data0,       32'h0000_4000);
        tick(1);
        chk("stop_r_chan", 32'(chan0), 1);
        tick(1);
        chk("stop_valid", 32'(valid0), 0);
        chk("stop_busy",  32'(busy0),  0);
        chk("stop_cnt",   32'(cnt0),   3);
        bad = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick(1);
            bad |= en0;
        end
        chk("stop_no_kick", 32'(bad), 0);
        // reset during SEND_R
        run = 1'b1;
        tick(6);
        chk("sr_chan",  32'(chan0),  1);
        chk("sr_valid", 32'(valid0), 1);
        reset = 1'b1;
        tick(1);
        chk("rst2_valid", 32'(valid0), 0);
        chk("rst2_chan",  32'(chan0),  0);
        chk("rst2_en",    32'(en0),    0);
        chk("rst2_busy",  32'(busy0),  0);
        chk("rst2_data",  data0,       0);
        chk("rst2_cnt",   32'(cnt0),   0);
        chk("rst2_iter",  32'(iter0),  0);
        chk("rst2_d1_to", 32'(to1),    0);
        // saturation with GAIN_SHIFT=2
        center_node = 18'h1FFFF;
        tick(1);
        reset = 1'b0;
        tick(5);
        chk("sat_pos_d1", data1, 32'h7FFF_FFFF);
        chk("nosat_d0",   data0, 32'h7FFF_C000);
        tick(1);
        center_node = 18'h20000;
        tick(5);
        chk("sat_neg_d1", data1, 32'h8000_0000);
        chk("neg_d0",     data0, 32'h8000_0000);
        // timeout on d1 with done never rising
        columns_done = '0;
        tick(49);
        chk("to_not_yet", 32'(to1),   0);
        chk("to_busy",    32'(busy1), 1);
        tick(6);
        chk("to_set",  32'(to1),   1);
        chk("to_idle", 32'(busy1), 0);
        columns_done = '1;
        bad = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick(1);
            bad |= en1;
        end
        chk("to_no_kick", 32'(bad), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
